// File: rtl/axi4_stream_byte_unshift_if.sv
// AXI4-Stream interface bundle shared by the byte unshift stage and its neighbours.
interface axi4_stream_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 1
);
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic [KEEP_WIDTH-1:0] tstrb;
  logic                  tlast;
  logic [ID_WIDTH-1:0]   tid;
  logic [DEST_WIDTH-1:0] tdest;
  logic [USER_WIDTH-1:0] tuser;

  modport master (
    output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
    output tready
  );
endinterface

// File: rtl/axi4_stream_byte_unshift.sv
// Strips the first shift_i bytes of every AXI4-Stream packet and realigns the
// remaining payload to byte lane 0. The shift is locked on each packet head.
// Optional feature macro: AXI4_STREAM_BYTE_UNSHIFT_DROP_CNT_EN adds drop_cnt_o,
// a saturating count of packets that vanished entirely (single beat, m <= s).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | hold empty, waiting for a packet head
// HOLD  | hold valid mid-packet, output = {input, hold} shifted down
// FLUSH | last fragment sits in hold, emitted alone while input stalls
module axi4_stream_byte_unshift #(
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 1,
  parameter int DEST_WIDTH     = 1,
  parameter int USER_WIDTH     = 1,
  parameter int DATA_WIDTH_B   = DATA_WIDTH / 8,
  parameter int DATA_WIDTH_B_W = $clog2(DATA_WIDTH_B)
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [DATA_WIDTH_B_W-1:0] shift_i,
  axi4_stream_if.slave              pkt_i,
  axi4_stream_if.master             pkt_o
`ifdef AXI4_STREAM_BYTE_UNSHIFT_DROP_CNT_EN
  ,
  output logic [15:0]               drop_cnt_o
`endif
);

  // Byte counts go up to 2*B (t = B - s + m), so two extra bits are enough.
  localparam int CW = DATA_WIDTH_B_W + 2;
  localparam logic [CW-1:0] B_C = CW'(DATA_WIDTH_B);

  typedef enum logic [1:0] {IDLE, HOLD, FLUSH} state_t;

  state_t                    state_q, state_d;
  logic [DATA_WIDTH-1:0]     hold_q;
  logic [DATA_WIDTH_B_W-1:0] s_lock_q;
  logic [CW-1:0]             rem_q, rem_d;
  logic [ID_WIDTH-1:0]       tid_q;
  logic [DEST_WIDTH-1:0]     tdest_q;
  logic [USER_WIDTH-1:0]     tuser_q;

  logic [CW-1:0]             in_m;
  logic [CW-1:0]             in_t;
  logic [CW-1:0]             s_lock_ext;
  logic [CW-1:0]             shift_ext;
  logic [DATA_WIDTH-1:0]     join_data;
  logic [DATA_WIDTH-1:0]     flush_data;
  logic                      load_hold;
  logic                      lock_head;
  logic                      drop_pkt;

  function automatic logic [DATA_WIDTH_B-1:0] ones(input logic [CW-1:0] n);
    logic [DATA_WIDTH_B-1:0] mask;
    mask = '0;
    for (int i = 0; i < DATA_WIDTH_B; i++) begin
      mask[i] = (CW'(i) < n);
    end
    return mask;
  endfunction

  assign s_lock_ext = {2'b00, s_lock_q};
  assign shift_ext  = {2'b00, shift_i};
  assign in_t       = B_C - s_lock_ext + in_m;

  // Valid byte count of the incoming beat (tkeep is contiguous from lane 0).
  always_comb begin
    in_m = '0;
    for (int i = 0; i < DATA_WIDTH_B; i++) begin
      in_m = in_m + {{(CW-1){1'b0}}, pkt_i.tkeep[i]};
    end
  end

  // Byte-lane realignment: mid-packet words splice hold with the new beat,
  // the flush word uses hold alone.
  always_comb begin
    join_data  = '0;
    flush_data = '0;
    for (int i = 0; i < DATA_WIDTH_B; i++) begin
      if (i + int'(s_lock_q) < DATA_WIDTH_B) begin
        join_data[8*i +: 8]  = hold_q[8*(i + int'(s_lock_q)) +: 8];
        flush_data[8*i +: 8] = hold_q[8*(i + int'(s_lock_q)) +: 8];
      end else begin
        join_data[8*i +: 8]  = pkt_i.tdata[8*(i + int'(s_lock_q) - DATA_WIDTH_B) +: 8];
      end
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state, handshake and output decode.
  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    load_hold     = 1'b0;
    lock_head     = 1'b0;
    drop_pkt      = 1'b0;
    pkt_i.tready  = 1'b0;
    pkt_o.tvalid  = 1'b0;
    pkt_o.tdata   = '0;
    pkt_o.tkeep   = '0;
    pkt_o.tlast   = 1'b0;
    unique case (state_q)
      IDLE: begin
        pkt_i.tready = 1'b1;
        if (pkt_i.tvalid) begin
          load_hold = 1'b1;
          lock_head = 1'b1;
          if (!pkt_i.tlast) begin
            state_d = HOLD;
          end else if (in_m > shift_ext) begin
            state_d = FLUSH;
            rem_d   = in_m - shift_ext;
          end else begin
            drop_pkt = 1'b1;
          end
        end
      end
      HOLD: begin
        pkt_i.tready = pkt_o.tready;
        pkt_o.tvalid = pkt_i.tvalid;
        pkt_o.tdata  = join_data;
        pkt_o.tkeep  = '1;
        // A short tail that fits in this word closes the packet right here.
        if (pkt_i.tlast && (in_t <= B_C)) begin
          pkt_o.tkeep = ones(in_t);
          pkt_o.tlast = 1'b1;
        end
        if (pkt_i.tvalid && pkt_o.tready) begin
          if (!pkt_i.tlast) begin
            load_hold = 1'b1;
          end else if (in_t <= B_C) begin
            state_d = IDLE;
          end else begin
            load_hold = 1'b1;
            rem_d     = in_m - s_lock_ext;
            state_d   = FLUSH;
          end
        end
      end
      FLUSH: begin
        pkt_o.tvalid = 1'b1;
        pkt_o.tdata  = flush_data;
        pkt_o.tkeep  = ones(rem_q);
        pkt_o.tlast  = 1'b1;
        if (pkt_o.tready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pkt_o.tstrb = pkt_o.tkeep;
  assign pkt_o.tid   = tid_q;
  assign pkt_o.tdest = tdest_q;
  assign pkt_o.tuser = tuser_q;

  // Hold word, locked shift, flush remainder and per-packet sideband.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hold_q   <= '0;
      s_lock_q <= '0;
      rem_q    <= '0;
      tid_q    <= '0;
      tdest_q  <= '0;
      tuser_q  <= '0;
    end else begin
      rem_q <= rem_d;
      if (load_hold) hold_q <= pkt_i.tdata;
      if (lock_head) begin
        s_lock_q <= shift_i;
        tid_q    <= pkt_i.tid;
        tdest_q  <= pkt_i.tdest;
        tuser_q  <= pkt_i.tuser;
      end
    end
  end

`ifdef AXI4_STREAM_BYTE_UNSHIFT_DROP_CNT_EN
  // Saturating count of packets swallowed whole by the shift.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                          drop_cnt_o <= '0;
    else if (drop_pkt && drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 16'd1;
  end
`else
  logic drop_unused;
  assign drop_unused = drop_pkt;
`endif

endmodule

// File: tb/tb_axi4_stream_byte_unshift.sv
// Randomized bench for axi4_stream_byte_unshift: a byte-queue reference model
// predicts every output beat from the packet bytes and the shift at the head.
module tb_axi4_stream_byte_unshift;
  localparam int DW  = 32;
  localparam int B   = DW / 8;
  localparam int IW  = 4;
  localparam int DSW = 3;
  localparam int UW  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] shift = 2'd0;

  always #5 clk = ~clk;

  axi4_stream_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .DEST_WIDTH(DSW), .USER_WIDTH(UW)) in_if ();
  axi4_stream_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .DEST_WIDTH(DSW), .USER_WIDTH(UW)) out_if ();

`ifdef AXI4_STREAM_BYTE_UNSHIFT_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  axi4_stream_byte_unshift #(
    .DATA_WIDTH(DW), .ID_WIDTH(IW), .DEST_WIDTH(DSW), .USER_WIDTH(UW)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .shift_i (shift),
    .pkt_i   (in_if),
    .pkt_o   (out_if)
`ifdef AXI4_STREAM_BYTE_UNSHIFT_DROP_CNT_EN
    ,
    .drop_cnt_o (drop_cnt)
`endif
  );

  typedef struct {
    logic [DW-1:0]  data;
    logic [B-1:0]   keep;
    logic           last;
    logic [IW-1:0]  id;
    logic [DSW-1:0] dest;
    logic [UW-1:0]  user;
  } beat_t;

  typedef struct {
    int len;
    int shift;     // -1 picks a random shift
    bit directed;  // bytes are 00,01,02,... instead of random
  } pkt_t;

  beat_t      exp_q[$];
  pkt_t       pend_q[$];
  logic [7:0] cur_bytes[$];
  bit         cur_active = 1'b0;
  int         cur_pos = 0;
  int         cur_shift = 0;
  logic [IW-1:0]  cur_id;
  logic [DSW-1:0] cur_dest;
  logic [UW-1:0]  cur_user;
  int         exp_drops = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: output stream is the packet bytes with the first s removed,
  // cut into B-byte words; an empty remainder means the packet is dropped.
  task automatic model_push(input int s, input logic [IW-1:0] id,
                            input logic [DSW-1:0] dest, input logic [UW-1:0] user);
    int n;
    beat_t b;
    n = cur_bytes.size() - s;
    if (n <= 0) begin
      exp_drops++;
      return;
    end
    for (int w = 0; w * B < n; w++) begin
      b.data = '0;
      b.keep = '0;
      for (int k = 0; k < B; k++) begin
        if (w * B + k < n) begin
          b.data[8*k +: 8] = cur_bytes[s + w * B + k];
          b.keep[k] = 1'b1;
        end
      end
      b.last = ((w + 1) * B >= n);
      b.id   = id;
      b.dest = dest;
      b.user = user;
      exp_q.push_back(b);
    end
  endtask

  task automatic start_next();
    pkt_t p;
    p = pend_q.pop_front();
    cur_bytes.delete();
    for (int i = 0; i < p.len; i++) cur_bytes.push_back(p.directed ? 8'(i) : 8'($urandom));
    cur_shift  = (p.shift < 0) ? int'($urandom_range(B - 1)) : p.shift;
    cur_id     = IW'($urandom);
    cur_dest   = DSW'($urandom);
    cur_user   = UW'($urandom);
    cur_pos    = 0;
    cur_active = 1'b1;
  endtask

  task automatic present_beat();
    int n;
    n = cur_bytes.size() - cur_pos;
    in_if.tvalid = 1'b1;
    for (int k = 0; k < B; k++) begin
      if (k < n) begin
        in_if.tdata[8*k +: 8] = cur_bytes[cur_pos + k];
        in_if.tkeep[k] = 1'b1;
      end else begin
        in_if.tdata[8*k +: 8] = 8'($urandom);
        in_if.tkeep[k] = 1'b0;
      end
    end
    in_if.tstrb = in_if.tkeep;
    in_if.tlast = (n <= B);
    if (cur_pos == 0) begin
      in_if.tid   = cur_id;
      in_if.tdest = cur_dest;
      in_if.tuser = cur_user;
    end else begin
      in_if.tid   = IW'($urandom);
      in_if.tdest = DSW'($urandom);
      in_if.tuser = UW'($urandom);
    end
  endtask

  // rdy_mode: 0 random, 1 always ready, 2 alternate 1,0,...
  task automatic run(input int rdy_mode, input int vld_pct, input int rst_at, input int budget);
    int    cyc;
    bit    in_fire, out_fire, prev_stall, done;
    beat_t prev, e;
    logic [DW-1:0] mask;
    cyc = 0;
    prev_stall = 1'b0;
    done = 1'b0;
    prev = '{default: '0};
    while (!done) begin
      @(negedge clk);
      in_fire  = in_if.tvalid && in_if.tready;
      out_fire = out_if.tvalid && out_if.tready;
      if (prev_stall) begin
        check_eq("stall_tvalid", out_if.tvalid, 1'b1);
        check_eq("stall_tdata",  out_if.tdata, prev.data);
        check_eq("stall_tkeep",  out_if.tkeep, prev.keep);
        check_eq("stall_tlast",  out_if.tlast, prev.last);
      end
      if (out_if.tvalid && !out_if.tready) check_eq("bp_in_ready", in_if.tready, 1'b0);
      if (in_fire && cur_pos == 0) model_push(int'(shift), in_if.tid, in_if.tdest, in_if.tuser);
      if (out_fire) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_beat", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          for (int k = 0; k < B; k++) mask[8*k +: 8] = {8{e.keep[k]}};
          check_eq("tdata", out_if.tdata & mask, e.data);
          check_eq("tkeep", out_if.tkeep, e.keep);
          check_eq("tstrb", out_if.tstrb, e.keep);
          check_eq("tlast", out_if.tlast, e.last);
          check_eq("tid",   out_if.tid, e.id);
          check_eq("tdest", out_if.tdest, e.dest);
          check_eq("tuser", out_if.tuser, e.user);
        end
      end
      prev_stall = out_if.tvalid && !out_if.tready;
      prev.data  = out_if.tdata;
      prev.keep  = out_if.tkeep;
      prev.last  = out_if.tlast;

      @(posedge clk);
      #1;
      cyc++;
      if (in_fire) begin
        cur_pos += B;
        if (cur_pos >= cur_bytes.size()) cur_active = 1'b0;
      end
      if (!cur_active && pend_q.size() > 0) start_next();
      if (cur_active) begin
        if (!(in_if.tvalid && !in_fire)) begin
          if (int'($urandom_range(99)) < vld_pct) present_beat();
          else begin
            in_if.tvalid = 1'b0;
            in_if.tdata  = DW'($urandom);
          end
        end
      end else begin
        in_if.tvalid = 1'b0;
      end
      if (cur_active && cur_pos == 0 && in_if.tvalid) shift = 2'(cur_shift);
      else                                           shift = 2'($urandom);
      case (rdy_mode)
        0:       out_if.tready = ($urandom_range(3) != 0);
        1:       out_if.tready = 1'b1;
        default: out_if.tready = ~out_if.tready;
      endcase

      if (cyc == rst_at) begin
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_async_tvalid", out_if.tvalid, 1'b0);
        check_eq("rst_in_ready", in_if.tready, 1'b1);
        exp_q.delete();
        cur_active   = 1'b0;
        in_if.tvalid = 1'b0;
        exp_drops    = 0;
        prev_stall   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
      end

      if (pend_q.size() == 0 && !cur_active && exp_q.size() == 0 && !out_if.tvalid) done = 1'b1;
      if (!done && cyc > budget) begin
        check_eq("timeout", 1'b1, 1'b0);
        pend_q.delete();
        exp_q.delete();
        cur_active   = 1'b0;
        in_if.tvalid = 1'b0;
        done = 1'b1;
      end
    end
    repeat (2) @(posedge clk);
    #1;
`ifdef AXI4_STREAM_BYTE_UNSHIFT_DROP_CNT_EN
    check_eq("drop_cnt", drop_cnt, 64'(exp_drops));
`endif
    check_eq("idle_in_ready", in_if.tready, 1'b1);
  endtask

  initial begin
    in_if.tvalid  = 1'b0;
    in_if.tdata   = '0;
    in_if.tkeep   = '0;
    in_if.tstrb   = '0;
    in_if.tlast   = 1'b0;
    in_if.tid     = '0;
    in_if.tdest   = '0;
    in_if.tuser   = '0;
    out_if.tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", in_if.tready, 1'b1);
    check_eq("rst_tvalid",   out_if.tvalid, 1'b0);
    check_eq("rst_tdata",    out_if.tdata, '0);
    check_eq("rst_tkeep",    out_if.tkeep, '0);
    check_eq("rst_tlast",    out_if.tlast, 1'b0);
    check_eq("rst_tid",      out_if.tid, '0);
`ifdef AXI4_STREAM_BYTE_UNSHIFT_DROP_CNT_EN
    check_eq("rst_drop_cnt", drop_cnt, '0);
`endif
    rst_n = 1'b1;

    // Directed: flush path, short tail, dropped packet, pass-through at s=0.
    pend_q.push_back('{len: 8, shift: 1, directed: 1'b1});
    pend_q.push_back('{len: 6, shift: 3, directed: 1'b1});
    pend_q.push_back('{len: 2, shift: 2, directed: 1'b1});
    pend_q.push_back('{len: 4, shift: 0, directed: 1'b1});
    pend_q.push_back('{len: 5, shift: 0, directed: 1'b1});
    run(1, 100, 0, 400);

    // Alternating backpressure over a 16-byte packet.
    out_if.tready = 1'b1;
    pend_q.push_back('{len: 16, shift: 1, directed: 1'b1});
    pend_q.push_back('{len: 13, shift: 2, directed: 1'b1});
    run(2, 100, 0, 400);

    // Reset in the middle of a packet, next packet must realign cleanly.
    pend_q.push_back('{len: 16, shift: 1, directed: 1'b1});
    pend_q.push_back('{len: 8,  shift: 2, directed: 1'b1});
    run(1, 100, 3, 400);

    // Randomized traffic with random gaps, stalls and shifts.
    for (int i = 0; i < 80; i++) begin
      pend_q.push_back('{len: int'($urandom_range(20, 1)), shift: -1, directed: 1'b0});
    end
    run(0, 70, 0, 6000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
